// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for the DVI/HDMI output path. Free-running
// horizontal/vertical counters give the pixel-request coordinate (x, y) to
// the upstream pixel source. The sync and data-enable flags decoded from that
// coordinate are delayed by PIPE_DELAY cycles. They then reach the TMDS
// channel coder in step with the pixel data the source returns for (x, y).
//
// Ports:
//   pxclk        in   1   pixel clock, sole clock
//   rst          in   1   asynchronous, active-low reset
//   x            out  CW  horizontal counter (pixel request column)
//   y            out  CW  vertical counter (pixel request line)
//   frame_start  out  1   high while (x, y) = (0, 0); not delayed
//   hsync        out  1   horizontal sync, polarity H_POL, delayed PIPE_DELAY
//   vsync        out  1   vertical sync, polarity V_POL, delayed PIPE_DELAY
//   visible      out  1   active-area flag, delayed PIPE_DELAY
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int PIPE_DELAY = 1,
    parameter int CW         = 11
) (
    input  logic          pxclk,
    input  logic          rst,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          visible
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries, sized to the counters so compares are width-matched.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HP = H_POL[0];
    localparam logic VP = V_POL[0];

    // Flag bit positions inside one delay stage.
    localparam int F_HS  = 2;
    localparam int F_VS  = 1;
    localparam int F_VIS = 0;

    // ---------------------------------------------------------------------
    // Stage 0: raster counters
    // ---------------------------------------------------------------------
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          frame_start_q;

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            // y only moves at a line wrap, so vsync changes on line boundaries.
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge pxclk or negedge rst) begin
        if (!rst) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b1;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            // Registered from the next state so it is high exactly while the
            // counters read (0,0), with no extra cycle of lag.
            frame_start_q <= (x_d == '0) && (y_d == '0);
        end
    end

    // ---------------------------------------------------------------------
    // Decode of the current coordinate (internal flags are active-high)
    // ---------------------------------------------------------------------
    logic       vis0, hs0, vs0;
    logic [2:0] dec0;

    always_comb begin
        vis0 = (x_q < H_ACT_C) && (y_q < V_ACT_C);
        hs0  = (x_q >= H_SS) && (x_q < H_SE);
        vs0  = (y_q >= V_SS) && (y_q < V_SE);
        dec0 = '0;
        dec0[F_HS]  = hs0;
        dec0[F_VS]  = vs0;
        dec0[F_VIS] = vis0;
    end

    // ---------------------------------------------------------------------
    // Delay line: PIPE_DELAY stages of {hs, vs, vis}. Reset clears every
    // stage to inactive, so a reset mid-frame cannot leave stale visible
    // pulses queued up behind it.
    // ---------------------------------------------------------------------
    logic [PIPE_DELAY-1:0][2:0] pipe_q;

    always_ff @(posedge pxclk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= dec0;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    logic [2:0] dly;
    assign dly = pipe_q[PIPE_DELAY-1];

    // XOR with the inverted polarity: active-low syncs come out inverted.
    assign hsync       = dly[F_HS] ^ ~HP;
    assign vsync       = dly[F_VS] ^ ~VP;
    assign visible     = dly[F_VIS];
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;

endmodule
